// File: rtl/xgmii_pkg.sv
// rtl/xgmii_pkg.sv - shared XGMII constants, packet-generator state type and MAC lane helper
// Optional feature macro: PKTGEN_CRC_EN (FCS appended in the TERM word).
package xgmii_pkg;

    localparam logic [63:0] XGMII_IDLE          = 64'h0707_0707_0707_0707;
    localparam logic [7:0]  XGMII_IDLE_CTRL     = 8'hFF;
    localparam logic [63:0] XGMII_START_WORD    = 64'hD555_5555_5555_55FB;
    localparam logic [7:0]  XGMII_START_CTRL    = 8'h01;
    localparam logic [63:0] XGMII_TERM_WORD     = 64'h0707_0707_0707_07FD;
    localparam logic [7:0]  XGMII_TERM_CTRL     = 8'hFF;
    // TERM word when the FCS occupies lanes 0-3.
    localparam logic [31:0] XGMII_TERM_CRC_HI   = 32'h0707_07FD;
    localparam logic [7:0]  XGMII_TERM_CRC_CTRL = 8'hF0;
    localparam logic [15:0] ETHERTYPE_PKTGEN    = 16'h88B5;
    localparam logic [31:0] CRC32_INIT          = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC32_POLY_REFL     = 32'hEDB8_8320;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_HDR0,
        ST_HDR1,
        ST_PAY,
        ST_TERM,
        ST_GAP
    } state_e;

    // MAC byte 0 is the first octet as written (most significant); it is
    // moved to bits [7:0] so it lands on the lowest lane.
    function automatic logic [47:0] mac_lanes(input logic [47:0] mac);
        return {mac[7:0], mac[15:8], mac[23:16], mac[31:24], mac[39:32], mac[47:40]};
    endfunction

endpackage

// File: rtl/crc32_d64.sv
// rtl/crc32_d64.sv - Ethernet CRC-32 over 64 bits per cycle, lane 0 first
// Ports: clk, rst (sync active-high), clr (load init), en (absorb data),
//        data[63:0] (lane 0 = bits 7:0), fcs[31:0] (final-XORed CRC, byte 0 in bits 7:0).
module crc32_d64
    import xgmii_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        en,
    input  logic [63:0] data,
    output logic [31:0] fcs
);

    logic [31:0] crc_q;
    logic [31:0] crc_d;

    // Reflected CRC: bit 0 of lane 0 is the first bit on the wire.
    function automatic logic [31:0] crc_step64(input logic [31:0] crc_in, input logic [63:0] d);
        logic [31:0] c;
        logic        fb;
        c = crc_in;
        for (int i = 0; i < 64; i++) begin
            fb = c[0] ^ d[i];
            c  = {1'b0, c[31:1]};
            if (fb) begin
                c = c ^ CRC32_POLY_REFL;
            end
        end
        return c;
    endfunction

    always_comb begin
        crc_d = crc_q;
        if (clr) begin
            crc_d = CRC32_INIT;
        end else if (en) begin
            crc_d = crc_step64(crc_q, data);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            crc_q <= CRC32_INIT;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign fcs = ~crc_q;

endmodule

// File: rtl/xgmii_pktgen.sv
// rtl/xgmii_pktgen.sv - XGMII 64-bit test-frame generator with programmable payload and gap
// Ports: clk156, sys_rst (sync active-high), enable, pay_words[LEN_W-1:0],
//        ifg_words[IFG_W-1:0], xgmii_txd[63:0], xgmii_txc[7:0], busy, frame_count[31:0].
// Optional feature macro: PKTGEN_CRC_EN (FCS in lanes 0-3 of the TERM word).
module xgmii_pktgen
    import xgmii_pkg::*;
#(
    parameter logic [47:0] DST_MAC = 48'hFFFF_FFFF_FFFF,
    parameter logic [47:0] SRC_MAC = 48'h0022_3344_5566,
    parameter int          LEN_W   = 8,
    parameter int          IFG_W   = 4
) (
    input  logic             clk156,
    input  logic             sys_rst,
    input  logic             enable,
    input  logic [LEN_W-1:0] pay_words,
    input  logic [IFG_W-1:0] ifg_words,
    output logic [63:0]      xgmii_txd,
    output logic [7:0]       xgmii_txc,
    output logic             busy,
    output logic [31:0]      frame_count
);

    localparam logic [47:0]      DST_L   = mac_lanes(DST_MAC);
    localparam logic [47:0]      SRC_L   = mac_lanes(SRC_MAC);
    localparam logic [63:0]      HDR0_W  = {SRC_L[15:0], DST_L};
    localparam logic [63:0]      HDR1_W  = {16'h0000, ETHERTYPE_PKTGEN[7:0],
                                            ETHERTYPE_PKTGEN[15:8], SRC_L[47:16]};
    localparam logic [LEN_W-1:0] LEN_ONE = {{(LEN_W-1){1'b0}}, 1'b1};
    localparam logic [IFG_W-1:0] IFG_ONE = {{(IFG_W-1){1'b0}}, 1'b1};

    state_e           state_q, state_d;
    logic [63:0]      txd_q, txd_d;
    logic [7:0]       txc_q, txc_d;
    logic [LEN_W-1:0] pay_n_q, pay_n_d;
    logic [IFG_W-1:0] ifg_n_q, ifg_n_d;
    logic [LEN_W-1:0] word_cnt_q, word_cnt_d;
    logic [IFG_W-1:0] gap_cnt_q, gap_cnt_d;
    logic [31:0]      frame_count_q, frame_count_d;
    logic [31:0]      word_idx;
    logic             start;

    assign word_idx = 32'(word_cnt_q);

`ifdef PKTGEN_CRC_EN
    logic [31:0] fcs;
    logic        crc_en;

    // txd_d is the word being registered, so the CRC register is up to date
    // with the last payload word by the time the state reaches TERM.
    assign crc_en = (state_q == ST_HDR0) || (state_q == ST_HDR1) || (state_q == ST_PAY);

    crc32_d64 u_crc (
        .clk  (clk156),
        .rst  (sys_rst),
        .clr  (state_q == ST_PRE),
        .en   (crc_en),
        .data (txd_d),
        .fcs  (fcs)
    );
`endif

    always_comb begin
        state_d       = state_q;
        pay_n_d       = pay_n_q;
        ifg_n_d       = ifg_n_q;
        word_cnt_d    = word_cnt_q;
        gap_cnt_d     = gap_cnt_q;
        frame_count_d = frame_count_q;
        txd_d         = XGMII_IDLE;
        txc_d         = XGMII_IDLE_CTRL;
        start         = 1'b0;

        case (state_q)
            ST_IDLE: begin
                start = enable;
            end
            ST_PRE: begin
                txd_d   = XGMII_START_WORD;
                txc_d   = XGMII_START_CTRL;
                state_d = ST_HDR0;
            end
            ST_HDR0: begin
                txd_d   = HDR0_W;
                txc_d   = 8'h00;
                state_d = ST_HDR1;
            end
            ST_HDR1: begin
                txd_d      = HDR1_W;
                txc_d      = 8'h00;
                word_cnt_d = '0;
                state_d    = ST_PAY;
            end
            ST_PAY: begin
                txc_d = 8'h00;
                // frame_count only moves in TERM, so it still holds the value from frame start.
                txd_d = (word_cnt_q == '0) ? {32'h0, frame_count_q} : {word_idx, word_idx};
                if (word_cnt_q == pay_n_q - LEN_ONE) begin
                    state_d = ST_TERM;
                end else begin
                    word_cnt_d = word_cnt_q + LEN_ONE;
                end
            end
            ST_TERM: begin
`ifdef PKTGEN_CRC_EN
                txd_d = {XGMII_TERM_CRC_HI, fcs};
                txc_d = XGMII_TERM_CRC_CTRL;
`else
                txd_d = XGMII_TERM_WORD;
                txc_d = XGMII_TERM_CTRL;
`endif
                frame_count_d = frame_count_q + 32'd1;
                gap_cnt_d     = '0;
                state_d       = ST_GAP;
            end
            ST_GAP: begin
                if (gap_cnt_q == ifg_n_q - IFG_ONE) begin
                    if (enable) begin
                        start = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    gap_cnt_d = gap_cnt_q + IFG_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Lengths are captured only here so mid-frame input changes are ignored.
        if (start) begin
            state_d = ST_PRE;
            pay_n_d = (pay_words == '0) ? LEN_ONE : pay_words;
            ifg_n_d = (ifg_words == '0) ? IFG_ONE : ifg_words;
        end
    end

    always_ff @(posedge clk156) begin
        if (sys_rst) begin
            state_q       <= ST_IDLE;
            txd_q         <= XGMII_IDLE;
            txc_q         <= XGMII_IDLE_CTRL;
            pay_n_q       <= LEN_ONE;
            ifg_n_q       <= IFG_ONE;
            word_cnt_q    <= '0;
            gap_cnt_q     <= '0;
            frame_count_q <= 32'd0;
        end else begin
            state_q       <= state_d;
            txd_q         <= txd_d;
            txc_q         <= txc_d;
            pay_n_q       <= pay_n_d;
            ifg_n_q       <= ifg_n_d;
            word_cnt_q    <= word_cnt_d;
            gap_cnt_q     <= gap_cnt_d;
            frame_count_q <= frame_count_d;
        end
    end

    assign xgmii_txd   = txd_q;
    assign xgmii_txc   = txc_q;
    assign busy        = (state_q != ST_IDLE);
    assign frame_count = frame_count_q;

endmodule

// File: doc/xgmii_pktgen.md
XGMII_PKTGEN -- requirements
Module: xgmii_pktgen

Interface
REQ-001 SHALL have parameter DST_MAC, 48'hFFFF_FFFF_FFFF, destination MAC address; byte 0 goes on lane 0.
REQ-002 SHALL have parameter SRC_MAC, 48'h0022_3344_5566, source MAC address; byte 0 goes on lane 0.
REQ-003 SHALL have parameter LEN_W, 8, width of the payload-length input.
REQ-004 SHALL have parameter IFG_W, 4, width of the inter-frame-gap input.
REQ-005 SHALL have port clk156, input, 1, the single 156.25 MHz clock; all logic is on its rising edge.
REQ-006 SHALL have port sys_rst, input, 1, reset that is synchronous and active-high.
REQ-007 SHALL have port enable, input, 1, which requests continuous frame generation.
REQ-008 SHALL have port pay_words, input, LEN_W, payload length in 64-bit words.
REQ-009 SHALL have port ifg_words, input, IFG_W, count of idle words between frames.
REQ-010 SHALL have port xgmii_txd, output, 64, registered XGMII TX data.
REQ-011 SHALL have port xgmii_txc, output, 8, registered XGMII TX control.
REQ-012 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-013 SHALL have port frame_count, output, 32, count of frames completed since reset.

Function
REQ-014 SHALL implement the states IDLE, PRE, HDR0, HDR1, PAY, TERM and GAP.
REQ-015 SHALL, in IDLE, output idle {txc 8'hFF, txd 64'h0707070707070707}, and go to PRE when enable=1.
REQ-016 SHALL, in PRE, output {8'h01, 64'hD5555555555555FB}.
REQ-017 SHALL output txc 8'h00 in HDR0, HDR1 and PAY.
REQ-018 SHALL, in HDR0, put DST_MAC[0..5] on lanes 0-5 and SRC_MAC[0..1] on lanes 6-7.
REQ-019 SHALL, in HDR1, put SRC_MAC[2..5] on lanes 0-3 and 8'h88, 8'hB5, 8'h00, 8'h00 on lanes 4-7.
REQ-020 SHALL latch pay_words and ifg_words on the IDLE/GAP-to-PRE transition only; input changes mid-frame have no effect.
REQ-021 SHALL treat a latched value of 0 as 1 for both pay_words and ifg_words.
REQ-022 SHALL emit payload word k, for k=0..N-1, as follows:
- k=0: {32'h0, seq}, where seq is the frame_count value at frame start.
- k>0: {k[31:0], k[31:0]}.
REQ-023 SHALL, in TERM, output {8'hFF, 64'h07070707070707FD}.
REQ-024 SHALL increment frame_count by 1 in the TERM cycle, wrapping from 32'hFFFFFFFF to 0.
REQ-025 SHALL, in GAP, output idle words for exactly the latched ifg count, then go to PRE if enable=1, else to IDLE.
REQ-026 SHALL always complete the current frame and its gap when enable drops mid-frame; no truncated frames.
REQ-027 SHALL have a latency of 1 clk156 cycle from state to output (registered outputs).
REQ-028 SHALL give a frame length, PRE to TERM inclusive, of N+4 cycles; back-to-back period N+4+G cycles.

Reset
REQ-029 SHALL, with sys_rst=1 at a clock edge, set state=IDLE, frame_count=0, busy=0 and the outputs to the idle word.
REQ-030 SHALL abort any frame in progress on reset; the next output word is idle, with no TERM emitted.
REQ-031 SHALL let sys_rst take priority over enable.

Configuration
REQ-032 SHALL, with PKTGEN_CRC_EN defined, accumulate Ethernet CRC-32 from HDR0 through the last PAY word (reflected, init 32'hFFFFFFFF, final XOR).
REQ-033 SHALL, with PKTGEN_CRC_EN defined, make TERM output {8'hF0, 8'h07,8'h07,8'h07,8'hFD, fcs[31:0]}, FCS byte 0 on lane 0.
REQ-034 SHALL, without PKTGEN_CRC_EN, emit no FCS and use the TERM word of REQ-023; frame length is unchanged in either build.

Structure
REQ-035 SHALL place the following in shared package xgmii_pkg:
- constants XGMII_IDLE, XGMII_START_WORD, XGMII_TERM_WORD, ETHERTYPE_PKTGEN (16'h88B5), CRC32_INIT;
- the state enum typedef.
REQ-036 SHALL place the CRC logic in one sub-module, crc32_d64: 64-bit data per cycle, with clear and enable controls.

Verification
REQ-037 SHALL cover: enable=1, pay_words=2, ifg_words=3 -> PRE, HDR0, HDR1, {0,0}, {1,1}, TERM, 3 idles, repeat every 9 cycles; frame_count=1 after the first TERM.
REQ-038 SHALL cover: pay_words=0, ifg_words=0 -> treated as 1/1; 6-cycle period; payload word {32'h0, seq}.
REQ-039 SHALL cover: enable dropped during PAY of a 10-word frame -> all 10 words, then TERM and gap, then IDLE; busy=0 afterwards.
REQ-040 SHALL cover: sys_rst during HDR1 -> idle word next cycle, frame_count=0, no TERM; with enable held, PRE follows once sys_rst is released.
REQ-041 SHALL cover: frame_count forced to 32'hFFFFFFFF -> seq word 32'hFFFFFFFF, then count wraps to 0 at TERM.
REQ-042 SHALL cover, with PKTGEN_CRC_EN: pay_words=4 -> TERM lanes 0-3 match the reference CRC-32 model; a capture decoded by a standard MAC checker shows no FCS error.
